vga_sync_receiver: RTL and testbench

- Receive end of the VGA timing interface: takes HS/VS as driven by the display timing generator and recovers the generator's col/row counters, blank and a lock indication.
- Used for loopback self-test of the timing generator and as the front end of a capture path that needs pixel coordinates aligned to the incoming sync.
- All counts are in clk_50 ticks: 2 ticks per pixel, 1600 ticks per line, 521 lines per frame.

---
 rtl/vga_sync_receiver.sv | 247 ++++++++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - recovers VGA row/col/blank and lock from incoming HS/VS
//
// Receive end of the VGA timing interface. Rebuilds the timing generator's
// tick/row counters from the incoming sync edges and judges every line and
// frame. It locks after enough good lines plus one good frame, and drops
// lock on a bad frame or on ERR_MAX consecutive bad lines.
// When aligned, row/col/blank trail the generator by exactly 2 clk_50 cycles.
//
// Ports:
//   clk_50       system clock, 2 ticks per pixel
//   rst_n        synchronous reset, active low
//   hs_in        horizontal sync, active low
//   vs_in        vertical sync, active low
//   row          recovered row, 0..V_TOTAL-1
//   col          recovered column, tick count bits [10:1]
//   blank        outside the display window or not locked
//   pixel_valid  locked and not blanked
//   locked       receiver is in LOCKED
//   h_err_count  bad lines seen while locked, saturating
//   v_err_count  bad frames seen while locked, saturating

module vga_sync_receiver #(
    parameter int H_TOTAL      = 1600,
    parameter int H_DISP       = 1280,
    parameter int H_SYNC_START = 1312,
    parameter int H_SYNC_W     = 192,
    parameter int V_TOTAL      = 521,
    parameter int V_DISP       = 480,
    parameter int V_SYNC_START = 490,
    parameter int LOCK_LINES   = 4,
    parameter int ERR_MAX      = 3
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       hs_in,
    input  logic       vs_in,
    output logic [9:0] row,
    output logic [9:0] col,
    output logic       blank,
    output logic       pixel_valid,
    output logic       locked,
    output logic [7:0] h_err_count,
    output logic [7:0] v_err_count
);

    localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_TOTAL_C   = 11'(H_TOTAL);
    localparam logic [10:0] H_DISP_LAST = 11'(H_DISP - 1);
    localparam logic [10:0] H_SYNC_LD   = 11'(H_SYNC_START + 1);
    localparam logic [7:0]  H_SYNC_W_C  = 8'(H_SYNC_W);
    localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_TOTAL_C   = 10'(V_TOTAL);
    localparam logic [9:0]  V_DISP_LAST = 10'(V_DISP - 1);
    localparam logic [9:0]  V_SYNC_LD   = 10'(V_SYNC_START);
    localparam logic [3:0]  LOCK_LAST   = 4'(LOCK_LINES - 1);
    localparam logic [3:0]  ERR_LAST    = 4'(ERR_MAX - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state, state_next;
    logic        hs_s1, hs_s2, hs_s3;
    logic        vs_s1, vs_s2, vs_s3;
    logic        hs_fall, vs_fall;
    logic [10:0] tick;
    logic [10:0] period;
    logic [7:0]  low_w;
    logic [9:0]  frame_cnt;
    logic [3:0]  vs_low_hs;
    logic        line_ref;
    logic [3:0]  good_cnt, good_next;
    logic [3:0]  bad_cnt, bad_next;
    logic        armed, armed_next;
    logic        line_judge, line_good, frame_good;
    logic        h_inc, v_inc;
    logic        enter_search;

    assign hs_fall = ~hs_s2 & hs_s3;
    assign vs_fall = ~vs_s2 & vs_s3;

    // At an HS edge, period holds the edge-to-edge distance and low_w still
    // holds the width of the pulse that started at the previous edge.
    assign line_judge = hs_fall & line_ref;
    assign line_good  = (period == H_TOTAL_C) && (low_w == H_SYNC_W_C);
    // An HS edge coincident with a VS edge is counted in the new frame.
    assign frame_good = (frame_cnt == V_TOTAL_C) && (vs_low_hs == 4'd2);

    assign col         = tick[10:1];
    assign locked      = (state == LOCKED);
    assign blank       = (tick > H_DISP_LAST) | (row > V_DISP_LAST) | ~locked;
    assign pixel_valid = locked & ~blank;

    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        bad_next   = bad_cnt;
        armed_next = armed;
        h_inc      = 1'b0;
        v_inc      = 1'b0;
        case (state)
            SEARCH: begin
                if (line_judge) begin
                    if (!line_good) begin
                        good_next = 4'd0;
                    end else if (good_cnt == LOCK_LAST) begin
                        state_next = ALIGN;
                        good_next  = 4'd0;
                        armed_next = 1'b0;
                    end else begin
                        good_next = good_cnt + 4'd1;
                    end
                end
            end
            ALIGN: begin
                // Line judgement takes priority over the frame judgement.
                if (line_judge && !line_good) begin
                    state_next = SEARCH;
                end else if (vs_fall) begin
                    if (!armed) begin
                        armed_next = 1'b1;
                    end else begin
                        state_next = frame_good ? LOCKED : SEARCH;
                    end
                end
            end
            LOCKED: begin
                if (line_judge) begin
                    if (line_good) begin
                        bad_next = 4'd0;
                    end else begin
                        h_inc    = 1'b1;
                        bad_next = bad_cnt + 4'd1;
                        if (bad_cnt == ERR_LAST) begin
                            state_next = SEARCH;
                        end
                    end
                end
                if (vs_fall && !frame_good) begin
                    v_inc      = 1'b1;
                    state_next = SEARCH;
                end
            end
            default: state_next = SEARCH;
        endcase
        enter_search = (state_next == SEARCH) && (state != SEARCH);
        if (enter_search) begin
            good_next = 4'd0;
            bad_next  = 4'd0;
        end
    end

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state       <= SEARCH;
            hs_s1       <= 1'b1;
            hs_s2       <= 1'b1;
            hs_s3       <= 1'b1;
            vs_s1       <= 1'b1;
            vs_s2       <= 1'b1;
            vs_s3       <= 1'b1;
            tick        <= 11'd0;
            row         <= 10'd0;
            period      <= 11'd0;
            low_w       <= 8'd0;
            frame_cnt   <= 10'd0;
            vs_low_hs   <= 4'd0;
            line_ref    <= 1'b0;
            good_cnt    <= 4'd0;
            bad_cnt     <= 4'd0;
            armed       <= 1'b0;
            h_err_count <= 8'd0;
            v_err_count <= 8'd0;
        end else begin
            state    <= state_next;
            good_cnt <= good_next;
            bad_cnt  <= bad_next;
            armed    <= armed_next;

            hs_s1 <= hs_in;
            hs_s2 <= hs_s1;
            hs_s3 <= hs_s2;
            vs_s1 <= vs_in;
            vs_s2 <= vs_s1;
            vs_s3 <= vs_s2;

            // The edge flag arrives 2 cycles after the generator's sync edge,
            // so loading H_SYNC_START+1 leaves tick exactly 2 cycles behind.
            if (hs_fall) begin
                tick <= H_SYNC_LD;
            end else if (tick == H_LAST) begin
                tick <= 11'd0;
            end else begin
                tick <= tick + 11'd1;
            end

            if (vs_fall) begin
                row <= V_SYNC_LD;
            end else if (tick == H_LAST) begin
                row <= (row == V_LAST) ? 10'd0 : row + 10'd1;
            end

            if (hs_fall) begin
                period <= 11'd1;
            end else if (period != 11'h7FF) begin
                period <= period + 11'd1;
            end

            if (!hs_s2) begin
                if (hs_s3) begin
                    low_w <= 8'd1;
                end else if (low_w != 8'hFF) begin
                    low_w <= low_w + 8'd1;
                end
            end

            if (vs_fall) begin
                frame_cnt <= {9'd0, hs_fall};
            end else if (hs_fall && frame_cnt != 10'h3FF) begin
                frame_cnt <= frame_cnt + 10'd1;
            end

            if (vs_fall) begin
                vs_low_hs <= {3'd0, hs_fall};
            end else if (hs_fall && !vs_s2 && vs_low_hs != 4'hF) begin
                vs_low_hs <= vs_low_hs + 4'd1;
            end

            // The first HS edge after entering SEARCH only sets the reference.
            if (enter_search) begin
                line_ref <= 1'b0;
            end else if (hs_fall) begin
                line_ref <= 1'b1;
            end

            if (h_inc && h_err_count != 8'hFF) begin
                h_err_count <= h_err_count + 8'd1;
            end
            if (v_inc && v_err_count != 8'hFF) begin
                v_err_count <= v_err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb/tb_vga_sync_receiver.sv - directed bench for vga_sync_receiver with a scaled loopback generator

module tb_vga_sync_receiver;

    localparam int H_TOTAL      = 40;
    localparam int H_DISP       = 32;
    localparam int H_SYNC_START = 34;
    localparam int H_SYNC_W     = 4;
    localparam int V_TOTAL      = 12;
    localparam int V_DISP       = 8;
    localparam int V_SYNC_START = 9;
    localparam int FRAME        = H_TOTAL * V_TOTAL;

    logic       clk_50;
    logic       rst_n;
    logic       hs_in;
    logic       vs_in;
    logic [9:0] row;
    logic [9:0] col;
    logic       blank;
    logic       pixel_valid;
    logic       locked;
    logic [7:0] h_err_count;
    logic [7:0] v_err_count;

    int n_checks = 0;
    int n_errors = 0;

    int gen_tick = 0, gen_row = 0;
    int d1_tick = 0, d1_row = 0, d2_tick = 0, d2_row = 0;
    int line_len = H_TOTAL, hs_w = H_SYNC_W, frame_len = V_TOTAL;
    int long_req = 0, long_done = 0;
    int narrow_req = 0, narrow_done = 0;
    int short_req = 0, short_done = 0;

    vga_sync_receiver #(
        .H_TOTAL(H_TOTAL), .H_DISP(H_DISP), .H_SYNC_START(H_SYNC_START),
        .H_SYNC_W(H_SYNC_W), .V_TOTAL(V_TOTAL), .V_DISP(V_DISP),
        .V_SYNC_START(V_SYNC_START), .LOCK_LINES(4), .ERR_MAX(3)
    ) dut (
        .clk_50(clk_50),
        .rst_n(rst_n),
        .hs_in(hs_in),
        .vs_in(vs_in),
        .row(row),
        .col(col),
        .blank(blank),
        .pixel_valid(pixel_valid),
        .locked(locked),
        .h_err_count(h_err_count),
        .v_err_count(v_err_count)
    );

    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    // Timing generator: one tick per clock, values change 1 time unit after the edge.
    initial begin
        hs_in = 1'b1;
        vs_in = 1'b1;
        forever begin
            @(posedge clk_50);
            #1;
            d2_tick = d1_tick; d2_row = d1_row;
            d1_tick = gen_tick; d1_row = gen_row;
            if (gen_tick >= line_len - 1) begin
                gen_tick = 0;
                if (gen_row >= frame_len - 1) begin
                    gen_row = 0;
                    if (short_req > short_done) begin
                        frame_len = V_TOTAL - 1;
                        short_done++;
                    end else begin
                        frame_len = V_TOTAL;
                    end
                end else begin
                    gen_row++;
                end
                if (long_req > long_done) begin
                    line_len = H_TOTAL + 1;
                    long_done++;
                end else begin
                    line_len = H_TOTAL;
                end
                if (narrow_req > narrow_done) begin
                    hs_w = H_SYNC_W - 1;
                    narrow_done++;
                end else begin
                    hs_w = H_SYNC_W;
                end
            end else begin
                gen_tick++;
            end
            hs_in = !(gen_tick >= H_SYNC_START && gen_tick < H_SYNC_START + hs_w);
            vs_in = !(gen_row >= V_SYNC_START && gen_row < V_SYNC_START + 2);
        end
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic wait_lock(input string tag, input int budget);
        int n;
        n = 0;
        while (locked !== 1'b1 && n < budget) begin
            @(negedge clk_50);
            n++;
        end
        check(tag, {31'd0, locked}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_locked"}, {31'd0, locked}, 32'd0);
        check({tag, "_row"}, {22'd0, row}, 32'd0);
        check({tag, "_col"}, {22'd0, col}, 32'd0);
        check({tag, "_blank"}, {31'd0, blank}, 32'd1);
        check({tag, "_pix"}, {31'd0, pixel_valid}, 32'd0);
        check({tag, "_herr"}, {24'd0, h_err_count}, 32'd0);
        check({tag, "_verr"}, {24'd0, v_err_count}, 32'd0);
    endtask

    initial begin
        int  n;
        int  exp_blank;
        bit  seen2;
        bit  hit;

        rst_n = 1'b0;
        repeat (3) @(negedge clk_50);
        check_reset_values("rst");
        rst_n = 1'b1;

        wait_lock("lock_initial", 3 * FRAME);

        // One full frame of recovered timing against the generator, 2 cycles late.
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk_50);
            exp_blank = (d2_tick >= H_DISP || d2_row >= V_DISP) ? 1 : 0;
            check("col", {22'd0, col}, 32'(d2_tick / 2));
            check("row", {22'd0, row}, 32'(d2_row));
            check("blank", {31'd0, blank}, 32'(exp_blank));
            check("pix", {31'd0, pixel_valid}, 32'(1 - exp_blank));
        end
        check("herr_clean", {24'd0, h_err_count}, 32'd0);
        check("verr_clean", {24'd0, v_err_count}, 32'd0);

        // Single long line.
        long_req = long_req + 1;
        repeat (4 * H_TOTAL) @(negedge clk_50);
        check("long1_herr", {24'd0, h_err_count}, 32'd1);
        check("long1_locked", {31'd0, locked}, 32'd1);

        // Single narrow HS pulse.
        narrow_req = narrow_req + 1;
        repeat (4 * H_TOTAL) @(negedge clk_50);
        check("narrow_herr", {24'd0, h_err_count}, 32'd2);
        check("narrow_locked", {31'd0, locked}, 32'd1);
        check("narrow_verr", {24'd0, v_err_count}, 32'd0);

        // One-cycle reset mid-line.
        repeat (13) @(negedge clk_50);
        rst_n = 1'b0;
        @(negedge clk_50);
        check_reset_values("midrst");
        rst_n = 1'b1;
        wait_lock("lock_after_rst", 3 * FRAME);

        // Three consecutive long lines lose lock on the third.
        long_req = long_req + 3;
        seen2 = 1'b0;
        hit = 1'b0;
        n = 0;
        while (!hit && n < 10 * H_TOTAL) begin
            @(negedge clk_50);
            n++;
            if (h_err_count == 8'd2 && !seen2) begin
                seen2 = 1'b1;
                check("long3_locked_at2", {31'd0, locked}, 32'd1);
            end
            if (h_err_count == 8'd3) begin
                hit = 1'b1;
                check("long3_locked_at3", {31'd0, locked}, 32'd0);
                check("long3_blank", {31'd0, blank}, 32'd1);
                check("long3_pix", {31'd0, pixel_valid}, 32'd0);
            end
        end
        check("long3_reached", {31'd0, hit}, 32'd1);
        wait_lock("lock_after_long3", 3 * FRAME);
        check("long3_herr_hold", {24'd0, h_err_count}, 32'd3);

        // Short frame loses lock at once; relock within two more frames.
        short_req = short_req + 1;
        hit = 1'b0;
        n = 0;
        while (!hit && n < 3 * FRAME) begin
            @(negedge clk_50);
            n++;
            if (v_err_count != 8'd0) begin
                hit = 1'b1;
                check("short_verr", {24'd0, v_err_count}, 32'd1);
                check("short_locked", {31'd0, locked}, 32'd0);
                check("short_herr", {24'd0, h_err_count}, 32'd3);
            end
        end
        check("short_reached", {31'd0, hit}, 32'd1);
        wait_lock("relock_short", 2 * FRAME + 2 * H_TOTAL);
        check("relock_verr", {24'd0, v_err_count}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
